// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order retirement.
// Entries are allocated at the tail by the issue stage and completed out of order
// by the CDB. Completed entries retire strictly in program order from the head,
// at most one per cycle, with a registered commit pulse.
//
// Ports:
//   clock, reset, flush         clock, synchronous active-high reset, synchronous clear
//   alloc_valid/rd/ready/tag    tail allocation handshake; tag is the current tail
//   cdb_valid/tag/value         result broadcast; marks a busy entry done
//   commit_valid/we/rd/value/tag registered retirement outputs for RF write and RAT clear
//   rob_empty, rob_count        occupancy status
module rob_commit_unit #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  output logic             commit_valid,
  output logic             commit_we,
  output logic [4:0]       commit_rd,
  output logic [XLEN-1:0]  commit_value,
  output logic [TAG_W-1:0] commit_tag,
  output logic             rob_empty,
  output logic [TAG_W:0]   rob_count
);

  localparam logic [TAG_W:0]   DepthCnt = TAG_W'(DEPTH) == '0 ? {1'b1, {TAG_W{1'b0}}}
                                                               : (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] PtrOne   = TAG_W'(1);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q    [DEPTH];
  logic [XLEN-1:0]  value_q [DEPTH];

  logic [TAG_W-1:0] head_q, tail_q;
  logic [TAG_W:0]   count_q, count_d;

  logic             commit_valid_q, commit_we_q;
  logic [4:0]       commit_rd_q;
  logic [XLEN-1:0]  commit_value_q;
  logic [TAG_W-1:0] commit_tag_q;

  logic alloc_fire;
  logic commit_fire;
  logic cdb_hit;

  always_comb begin
    alloc_ready = (count_q != DepthCnt);
    alloc_fire  = alloc_valid && alloc_ready;
    commit_fire = busy_q[head_q] && done_q[head_q];
    cdb_hit     = cdb_valid && busy_q[cdb_tag];

    count_d = count_q;
    unique case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_we_q    <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_tag_q   <= '0;
    end else begin
      // Order matters: a repeat CDB hit on the retiring head must not resurrect
      // it, so the commit clear is written after the CDB update.
      if (cdb_hit) begin
        done_q[cdb_tag]  <= 1'b1;
        value_q[cdb_tag] <= cdb_value;
      end

      commit_valid_q <= commit_fire;
      commit_we_q    <= commit_fire && (rd_q[head_q] != 5'd0);
      if (commit_fire) begin
        commit_rd_q    <= rd_q[head_q];
        commit_value_q <= value_q[head_q];
        commit_tag_q   <= head_q;
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + PtrOne;
      end

      // Tail never equals a retiring head: that needs empty (no commit) or full (no alloc).
      if (alloc_fire) begin
        busy_q[tail_q]  <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        rd_q[tail_q]    <= alloc_rd;
        value_q[tail_q] <= '0;
        tail_q          <= tail_q + PtrOne;
      end

      count_q <= count_d;
    end
  end

  assign alloc_tag    = tail_q;
  assign commit_valid = commit_valid_q;
  assign commit_we    = commit_we_q;
  assign commit_rd    = commit_rd_q;
  assign commit_value = commit_value_q;
  assign commit_tag   = commit_tag_q;
  assign rob_empty    = (count_q == '0);
  assign rob_count    = count_q;

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
Reorder buffer and in-order retirement engine for the Tomasulo RV32I core. It accepts entry allocations from the issue stage at the tail and captures execution results from the CDB. It retires completed entries strictly in program order from the head, producing one register-file write per cycle together with the tag that the RAT uses to clear pending-producer state. It is the consumer end of the issue stage's RoB-tail writes.

Parameters:
DEPTH, 8, number of RoB entries (power of two, >=2)
TAG_W, 3, log2(DEPTH); width of RoB tags
XLEN, 32, data width

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
flush  in  1  synchronous clear of all entries (misprediction/exception), same effect as reset
alloc_valid  in  1  issue stage requests a new entry this cycle
alloc_rd  in  5  destination architectural register of the new entry
alloc_ready  out  1  entry available (count < DEPTH); combinational from registered count
alloc_tag  out  TAG_W  tag granted to the allocation (current tail pointer)
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  RoB tag of the broadcast result
cdb_value  in  XLEN  broadcast result value
commit_valid  out  1  registered one-cycle pulse: an entry retired
commit_we  out  1  commit_valid and commit_rd != 0
commit_rd  out  5  retired destination register
commit_value  out  XLEN  retired result
commit_tag  out  TAG_W  retired entry tag; RAT clears its valid-pending state only if register_tag[commit_rd] == commit_tag
rob_empty  out  1  count == 0
rob_count  out  TAG_W+1  number of occupied entries

Behaviour:
- Per entry: busy, done, rd[4:0], value[XLEN-1:0]. Pointers: head, tail (TAG_W bits, wrap modulo DEPTH); count (TAG_W+1 bits).
- Reset or flush: head=tail=count=0; all busy/done=0; commit_valid=commit_we=0, commit_rd=0, commit_value=0, commit_tag=0. Reset or flush wins over any simultaneous alloc, CDB or commit in that cycle. Reset mid-stream discards all in-flight entries.
- Allocation: accepted when alloc_valid && alloc_ready. The entry at tail gets busy=1, done=0, rd=alloc_rd, value=0. Tail increments with wrap 7->0. alloc_tag equals the pre-increment tail. alloc_valid while !alloc_ready is ignored, with no state change.
- CDB capture: if cdb_valid && busy[cdb_tag], set done=1 and value=cdb_value. A CDB hit on a non-busy entry is ignored. A repeated CDB hit on a done entry overwrites value.
- Commit: evaluated on registered state at each edge. If busy[head] && done[head], then:
  - commit_valid<=1; commit_rd/value/tag <= entry fields; commit_we <= (rd != 0);
  - busy[head]<=0, done[head]<=0; head increments with wrap.
  - Otherwise commit_valid<=0 and commit_we<=0; commit_rd/value/tag hold their last values.
- Latency: a CDB result at edge N sets done. The earliest commit pulse is registered at edge N+1. There is no CDB-to-commit bypass. At most one commit per cycle.
- Count: +1 on accepted alloc, -1 on commit, unchanged when both occur in the same cycle.
- Full with simultaneous commit: alloc_ready reflects the pre-edge count, so no allocation is accepted while full, even when an entry retires that cycle.
- Allocation into the slot being freed in the same cycle cannot occur: the tail equals the head only when the buffer is empty or full.
- CDB and allocation to the same tag in one cycle cannot occur, because that slot is non-busy; the CDB is ignored per the rule above.

Test Plan:
- Reset, then allocate rd=5,6,7 (tags 0,1,2). CDB tag1=0x22, tag0=0x11, tag2=0x33 in separate cycles -> commits in order: (rd5,0x11,tag0), (rd6,0x22,tag1), (rd7,0x33,tag2). Tag0 commits the cycle after its CDB; rob_empty=1 afterwards.
- Fill 8 entries -> alloc_ready=0, rob_count=8. A 9th alloc_valid is ignored. Complete head and assert alloc_valid in the same cycle -> alloc still rejected; accepted next cycle with alloc_tag=0 after the tail wraps.
- Allocate rd=0, CDB value 0xDEAD -> commit_valid=1, commit_we=0, commit_rd=0.
- Issue 10 alloc/complete pairs so the pointers wrap past 7 -> tags returned are 0..7,0,1; commits remain in order with correct values.
- 4 entries in flight, 2 done; assert flush together with alloc_valid and cdb_valid -> next cycle count=0, rob_empty=1, commit_valid=0; subsequent alloc gets tag 0.
- CDB with tag 3 while entry 3 is not busy -> no state change; a later alloc into tag 3 starts with done=0.
